// File: rtl/scan_decoder.sv
// scan_decoder: registered binary-to-one-hot decoder with a built-in scan
// sequencer. In direct mode it drives the line selected by a latched code.
// In scan mode it walks the active line through 0..scan_last, dwelling DWELL
// cycles on each index and pulsing wrap when it returns to 0.
// Every output is taken straight from a flop, so the selects never glitch.
//
// Input handshake: din_valid is a one-sided strobe with no ready. On every
// rising edge where din_valid=1, din is captured into the code register,
// whatever the current state. The block never applies backpressure.
module scan_decoder #(
    parameter int SEL_W      = 4,
    parameter int DWELL      = 1000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        din,
    input  logic                    din_valid,
    input  logic [SEL_W-1:0]        scan_last,
    output logic [(1<<SEL_W)-1:0]   dout,
    output logic [SEL_W-1:0]        idx,
    output logic                    wrap,
    output logic [1:0]              dbg_state_o
);

    localparam int OUT_W = 1 << SEL_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    // XOR mask turning an active-high one-hot into the chosen polarity;
    // it is also the all-inactive pattern.
    localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   code_q,  code_d;
    logic [SEL_W-1:0]   idx_q,   idx_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               wrap_q,  wrap_d;
    logic [OUT_W-1:0]   dout_q,  dout_d;
    logic [OUT_W-1:0]   sel_d;

    // Next state is decoded straight from en/mode every cycle.
    always_comb begin
        state_d = IDLE;
        if (en) begin
            state_d = mode ? SCAN : DIRECT;
        end
    end

    // Next values of code register, scan position and registered outputs.
    always_comb begin
        code_d = din_valid ? din : code_q;
        idx_d  = '0;
        cnt_d  = '0;
        wrap_d = 1'b0;
        case (state_d)
            DIRECT: begin
                // No bypass: a code loaded this edge shows up one edge later.
                idx_d = code_q;
            end
            SCAN: begin
                if (state_q != SCAN) begin
                    // Fresh entry always restarts the walk at index 0.
                    idx_d = '0;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    // scan_last is compared live, so lowering it below the
                    // current index makes the next advance wrap.
                    if (idx_q >= scan_last) begin
                        idx_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        idx_d = idx_q + SEL_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    idx_d = idx_q;
                end
            end
            default: begin
                idx_d = '0;
            end
        endcase

        sel_d = '0;
        if (state_d != IDLE) begin
            sel_d[idx_d] = 1'b1;
        end
        dout_d = sel_d ^ INACTIVE;
    end

    // State, code, scan position and outputs; async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            dout_q  <= INACTIVE;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            dout_q  <= dout_d;
        end
    end

    assign dout        = dout_q;
    assign idx         = idx_q;
    assign wrap        = wrap_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Testbench for scan_decoder. Two instances share inputs: u0 uses
// SEL_W=4/DWELL=3/active-high, u1 uses SEL_W=4/DWELL=1/active-low.
// The driver pushes hand-computed expected outputs per edge; a monitor
// pops and compares shortly after each rising edge.
module tb_scan_decoder;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        en, mode, din_valid;
    logic [3:0]  din, scan_last;
    logic [15:0] dout0, dout1;
    logic [3:0]  idx0, idx1;
    logic        wrap0, wrap1;
    logic [1:0]  st0, st1;

    scan_decoder #(.SEL_W(4), .DWELL(3), .ACTIVE_LOW(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din(din),
        .din_valid(din_valid), .scan_last(scan_last), .dout(dout0),
        .idx(idx0), .wrap(wrap0), .dbg_state_o(st0)
    );

    scan_decoder #(.SEL_W(4), .DWELL(1), .ACTIVE_LOW(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din(din),
        .din_valid(din_valid), .scan_last(scan_last), .dout(dout1),
        .idx(idx1), .wrap(wrap1), .dbg_state_o(st1)
    );

    // ---------------- scoreboard ----------------
    // entry = {which_dut, dout[15:0], idx[3:0], wrap}
    logic [21:0] exp_q[$];
    string       name_q[$];
    int          pass_cnt  = 0;
    int          total_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Monitor: compare the selected instance against the oldest expectation.
    always @(posedge clk) begin
        logic [21:0] e;
        logic [21:0] a;
        string       nm;
        #2;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e[21]) a = {1'b1, dout1, idx1, wrap1};
            else       a = {1'b0, dout0, idx0, wrap0};
            chk(nm, 32'(a), 32'(e));
        end
    end

    // ---------------- driver ----------------
    // Called at a falling edge: drives inputs, records what the chosen
    // instance must show after the next rising edge, waits one cycle.
    task automatic step(input logic e, input logic m, input logic [3:0] d,
                        input logic dv, input logic [3:0] sl, input logic s,
                        input logic [3:0] ei, input logic ea, input logic ew,
                        input string nm);
        logic [15:0] one;
        logic [15:0] ed;
        en = e; mode = m; din = d; din_valid = dv; scan_last = sl;
        one = 16'h0001;
        ed  = ea ? (one << ei) : 16'h0000;
        if (s) ed = ~ed;
        exp_q.push_back({s, ed, ei, ew});
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int scan_tab[12];
    int live_tab[13];

    initial begin
        scan_tab = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 0, 0};
        live_tab = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4, 4, 5};

        rst_n = 1'b0;
        en = 1'b1; mode = 1'b1; din = 4'h0; din_valid = 1'b0; scan_last = 4'd2;
        repeat (3) @(negedge clk);
        chk("rst_dout0", 32'(dout0), 32'h0000);
        chk("rst_idx0",  32'(idx0),  32'h0);
        chk("rst_wrap0", 32'(wrap0), 32'h0);
        chk("rst_dout1", 32'(dout1), 32'hFFFF);
        rst_n = 1'b1;

        // scan with scan_last=2, DWELL=3: wrap on the tenth cycle
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 4'h0, 0, 4'd2, 0, 4'(scan_tab[i]), 1, (i == 9), $sformatf("scan2_%0d", i));
        end

        // raise scan_last to 7, walk to index 5
        for (int i = 0; i < 13; i++) begin
            step(1, 1, 4'h0, 0, 4'd7, 0, 4'(live_tab[i]), 1, 0, $sformatf("walk7_%0d", i));
        end
        // lower scan_last to 3 while at index 5: next dwell end wraps
        step(1, 1, 4'h0, 0, 4'd3, 0, 4'd5, 1, 0, "live_a");
        step(1, 1, 4'h0, 0, 4'd3, 0, 4'd5, 1, 0, "live_b");
        step(1, 1, 4'h0, 0, 4'd3, 0, 4'd0, 1, 1, "live_wrap");
        step(1, 1, 4'h0, 0, 4'd3, 0, 4'd0, 1, 0, "s3_a");
        step(1, 1, 4'h0, 0, 4'd3, 0, 4'd0, 1, 0, "s3_b");
        step(1, 1, 4'h0, 0, 4'd3, 0, 4'd1, 1, 0, "s3_c");
        step(1, 1, 4'h0, 0, 4'd3, 0, 4'd1, 1, 0, "s3_d");
        step(1, 1, 4'h0, 0, 4'd3, 0, 4'd1, 1, 0, "s3_e");
        step(1, 1, 4'h0, 0, 4'd3, 0, 4'd2, 1, 0, "s3_idx2");

        // at idx 2 switch to direct while loading 0xB: old code 0 shown first
        step(1, 0, 4'hB, 1, 4'd3, 0, 4'd0, 1, 0, "dir_switch");
        step(1, 0, 4'h3, 0, 4'd3, 0, 4'hB, 1, 0, "dir_B");
        step(1, 0, 4'h5, 0, 4'd3, 0, 4'hB, 1, 0, "dir_hold");

        // back to scan restarts at 0, then en=0 mid-dwell
        step(1, 1, 4'h5, 0, 4'd3, 0, 4'd0, 1, 0, "rescan_0");
        step(1, 1, 4'h5, 0, 4'd3, 0, 4'd0, 1, 0, "rescan_1");
        step(0, 1, 4'h5, 0, 4'd3, 0, 4'd0, 0, 0, "idle_mid");

        // scan_last=0: wrap every 3 cycles; en falls on a terminal cycle
        step(1, 1, 4'h5, 0, 4'd0, 0, 4'd0, 1, 0, "sl0_a");
        step(1, 1, 4'h5, 0, 4'd0, 0, 4'd0, 1, 0, "sl0_b");
        step(1, 1, 4'h5, 0, 4'd0, 0, 4'd0, 1, 0, "sl0_c");
        step(1, 1, 4'h5, 0, 4'd0, 0, 4'd0, 1, 1, "sl0_wrap");
        step(1, 1, 4'h5, 0, 4'd0, 0, 4'd0, 1, 0, "sl0_d");
        step(1, 1, 4'h5, 0, 4'd0, 0, 4'd0, 1, 0, "sl0_e");
        step(0, 1, 4'h5, 0, 4'd0, 0, 4'd0, 0, 0, "idle_terminal");
        step(0, 1, 4'h5, 0, 4'd0, 0, 4'd0, 0, 0, "idle_hold");
        step(1, 0, 4'h5, 0, 4'd0, 0, 4'hB, 1, 0, "idle_to_dir");

        // active-low, DWELL=1 instance: full walk 0..15, wrap every 16
        for (int i = 0; i < 34; i++) begin
            step(1, 1, 4'h5, 0, 4'd15, 1, 4'(i % 16), 1, (i == 16 || i == 32),
                 $sformatf("al_%0d", i));
        end

        // reset asserted between edges mid-scan acts immediately
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_dout1", 32'(dout1), 32'hFFFF);
        chk("async_idx1",  32'(idx1),  32'h0);
        chk("async_wrap1", 32'(wrap1), 32'h0);
        chk("async_dout0", 32'(dout0), 32'h0000);
        chk("async_idx0",  32'(idx0),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 4'h5, 0, 4'd15, 1, 4'd0, 0, 0, "al_idle");
        step(1, 1, 4'h5, 0, 4'd15, 1, 4'd0, 1, 0, "al_restart");
        step(1, 1, 4'h5, 0, 4'd15, 1, 4'd1, 1, 0, "al_next");

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) chk("drain", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
